// File: rtl/led_matrix_pwm_pkg.sv
// Shared definitions for the LED matrix PWM scanner: slot arithmetic,
// width helper and drive-polarity constants.
package led_matrix_pwm_pkg;

  localparam bit POL_ACTIVE_HIGH = 1'b1;
  localparam bit POL_ACTIVE_LOW  = 1'b0;

  // Blanking slots plus one slot per non-zero brightness level.
  function automatic int slot_count(input int bpp, input int blank_slots);
    return blank_slots + (32'sd1 <<< bpp) - 32'sd1;
  endfunction

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 32'sd1;
    while ((32'sd1 <<< w) < value) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_matrix_pwm_scan_tick_gen.sv
// Slot tick divider: one-cycle tick every TICK_DIV clocks while enabled,
// counter parked at zero while scanning is off.
module scan_tick_gen
  import led_matrix_pwm_pkg::*;
#(
  parameter int TICK_DIV = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int            CW       = clog2_min1(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // divider counter, restarts from zero whenever enable drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!enable) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/led_matrix_pwm.sv
// Row-scanned LED matrix driver with per-pixel PWM brightness and a
// double-buffered frame that only swaps at the frame boundary.
module led_matrix_pwm
  import led_matrix_pwm_pkg::*;
#(
  parameter int ROWS            = 6,
  parameter int COLS            = 6,
  parameter int BPP             = 4,
  parameter int TICK_DIV        = 64,
  parameter int BLANK_SLOTS     = 1,
  parameter bit ROW_ACTIVE_HIGH = 1'b1,
  parameter bit COL_ACTIVE_HIGH = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [ROWS*COLS*BPP-1:0] img,
  input  logic                     load,
  output logic [ROWS-1:0]          row,
  output logic [COLS-1:0]          col,
  output logic                     frame_start,
  output logic                     pending
);

  localparam int              S         = slot_count(BPP, BLANK_SLOTS);
  localparam int              SW        = clog2_min1(S);
  localparam int              RW        = clog2_min1(ROWS);
  localparam int              FW        = ROWS * COLS * BPP;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(S - 1);
  localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
  // XOR masks: idle level doubles as the inversion applied to active-high terms
  localparam logic [ROWS-1:0] ROW_IDLE  = (ROW_ACTIVE_HIGH == POL_ACTIVE_HIGH) ? '0 : '1;
  localparam logic [COLS-1:0] COL_IDLE  = (COL_ACTIVE_HIGH == POL_ACTIVE_LOW) ? '1 : '0;

  logic            tick_s;
  logic            wrap_s;
  logic            swap_s;
  logic            in_blank_s;
  logic [SW-1:0]   pwm_s;
  logic [ROWS-1:0] row_act_s;
  logic [COLS-1:0] col_act_s;

  logic [SW-1:0]   slot_r;
  logic [RW-1:0]   row_idx_r;
  logic            slot_first_r;
  logic            pending_r;
  logic [FW-1:0]   pend_buf_r;
  logic [FW-1:0]   act_buf_r;

  scan_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick_s)
  );

  assign wrap_s  = tick_s && (slot_r == SLOT_LAST) && (row_idx_r == ROW_LAST);
  assign swap_s  = wrap_s && pending_r;
  assign pwm_s   = slot_r - SW'(BLANK_SLOTS);
  assign pending = pending_r;

  if (BLANK_SLOTS == 0) begin : g_no_blank
    assign in_blank_s = 1'b0;
  end else begin : g_blank
    assign in_blank_s = (slot_r < SW'(BLANK_SLOTS));
  end

  // slot and row counters; zeroed while disabled so a restart begins at row 0 slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r    <= '0;
      row_idx_r <= '0;
    end else if (!enable) begin
      slot_r    <= '0;
      row_idx_r <= '0;
    end else if (tick_s) begin
      if (slot_r == SLOT_LAST) begin
        slot_r    <= '0;
        row_idx_r <= (row_idx_r == ROW_LAST) ? '0 : row_idx_r + RW'(1'b1);
      end else begin
        slot_r    <= slot_r + SW'(1'b1);
      end
    end else begin
      slot_r    <= slot_r;
      row_idx_r <= row_idx_r;
    end
  end

  // active-high row select and PWM column compare for the current counter state
  always_comb begin
    row_act_s = '0;
    col_act_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_act_s[r] = (row_idx_r == RW'(r)) && !in_blank_s;
      for (int c = 0; c < COLS; c++) begin
        col_act_s[c] = col_act_s[c] |
                       (row_act_s[r] && (SW'(act_buf_r[(r*COLS+c)*BPP +: BPP]) > pwm_s));
      end
    end
  end

  // registered drive outputs; slot_first_r marks the first clock of each slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row          <= ROW_IDLE;
      col          <= COL_IDLE;
      frame_start  <= 1'b0;
      slot_first_r <= 1'b1;
    end else begin
      slot_first_r <= !enable || tick_s;
      if (!enable) begin
        row         <= ROW_IDLE;
        col         <= COL_IDLE;
        frame_start <= 1'b0;
      end else begin
        row         <= row_act_s ^ ROW_IDLE;
        col         <= col_act_s ^ COL_IDLE;
        frame_start <= slot_first_r && (slot_r == '0) && (row_idx_r == '0);
      end
    end
  end

  // frame double buffer: a load always wins the pending flag over a same-cycle swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_buf_r <= '0;
      act_buf_r  <= '0;
      pending_r  <= 1'b0;
    end else begin
      if (swap_s) begin
        act_buf_r <= pend_buf_r;
      end else begin
        act_buf_r <= act_buf_r;
      end
      if (load) begin
        pend_buf_r <= img;
        pending_r  <= 1'b1;
      end else if (swap_s) begin
        pending_r  <= 1'b0;
      end else begin
        pending_r  <= pending_r;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Self-checking bench for led_matrix_pwm (2x2 matrix, 2 bpp, 4 clk per slot):
// cycle scoreboard against a time-based model plus PWM table and corner sequences.
module tb_led_matrix_pwm;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int BPP  = 2;
  localparam int TD   = 4;
  localparam int BL   = 1;
  localparam int S    = 4;
  localparam int FRM  = 32;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic       load   = 1'b0;
  logic [7:0] img    = 8'h00;
  logic [1:0] row;
  logic [1:0] col;
  logic       frame_start;
  logic       pending;

  led_matrix_pwm #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .BPP         (BPP),
    .TICK_DIV    (TD),
    .BLANK_SLOTS (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .img         (img),
    .load        (load),
    .row         (row),
    .col         (col),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
    logic       fs;
    logic       pend;
  } exp_t;

  typedef struct packed {
    logic [7:0]  img;
    logic [15:0] exp_cyc;  // lit clocks per pixel, 4 bits each, pixel 0 in LSBs
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // bench model state: m_t counts enabled clocks since scanning (re)started
  int         m_t       = 0;
  logic [7:0] m_act     = 8'h00;
  logic [7:0] m_pend    = 8'h00;
  logic       m_pending = 1'b0;

  logic [1:0] obs_row;
  logic [1:0] obs_col;
  logic       obs_fs;
  logic       obs_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pix(input logic [7:0] f, input int r, input int c);
    logic [7:0] sh;
    sh = f >> ((r * COLS + c) * BPP);
    return int'(sh[1:0]);
  endfunction

  task automatic model_step(input logic en, input logic ld, input logic [7:0] im, output exp_t e);
    int   slot;
    int   r;
    int   p;
    logic wrap;
    logic swap;
    e.row = 2'b00;
    e.col = 2'b11;
    e.fs  = 1'b0;
    wrap  = 1'b0;
    if (en) begin
      slot = (m_t / TD) % S;
      r    = (m_t / (TD * S)) % ROWS;
      e.fs = ((m_t % FRM) == 0);
      wrap = ((m_t % FRM) == FRM - 1);
      if (slot >= BL) begin
        p = slot - BL;
        e.row[r] = 1'b1;
        for (int c = 0; c < COLS; c++) begin
          if (pix(m_act, r, c) > p) e.col[c] = 1'b0;
        end
      end
      m_t++;
    end else begin
      m_t = 0;
    end
    swap = wrap && m_pending;
    if (swap) m_act = m_pend;
    if (ld) begin
      m_pend    = im;
      m_pending = 1'b1;
    end else if (swap) begin
      m_pending = 1'b0;
    end
    e.pend = m_pending;
  endtask

  task automatic cycle(input logic en, input logic ld, input logic [7:0] im);
    exp_t e;
    exp_t got;
    enable = en;
    load   = ld;
    img    = im;
    model_step(en, ld, im, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    obs_row  = row;
    obs_col  = col;
    obs_fs   = frame_start;
    obs_pend = pending;
    got.row  = row;
    got.col  = col;
    got.fs   = frame_start;
    got.pend = pending;
    e = sb_q.pop_front();
    check("scan_out", {26'd0, got}, {26'd0, e});
    check("row_onehot0", {31'd0, $onehot0(row)}, 32'd1);
  endtask

  task automatic align(input int k);
    int n;
    n = 0;
    while (((m_t % FRM) != k) && (n < 64)) begin
      cycle(1'b1, 1'b0, img);
      n++;
    end
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      cycle(1'b1, 1'b0, img);
      n++;
    end while (!obs_fs && (n < 80));
    check("fs_wait", {31'd0, obs_fs}, 32'd1);
  endtask

  task automatic count_frame(input logic [15:0] exp_cyc, input string name);
    int lit[4];
    for (int i = 0; i < 4; i++) lit[i] = 0;
    wait_fs();
    for (int k = 0; k < FRM; k++) begin
      if (k > 0) cycle(1'b1, 1'b0, img);
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (obs_row[r] && !obs_col[c]) lit[r*COLS+c]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check(name, 32'(lit[i]), {28'd0, exp_cyc[i*4 +: 4]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_fs;
    int n_fs;
    int n;

    vecs[0].img = 8'hE4; vecs[0].exp_cyc = {4'd12, 4'd8,  4'd4,  4'd0};
    vecs[1].img = 8'h1B; vecs[1].exp_cyc = {4'd0,  4'd4,  4'd8,  4'd12};
    vecs[2].img = 8'h00; vecs[2].exp_cyc = {4'd0,  4'd0,  4'd0,  4'd0};
    vecs[3].img = 8'hFF; vecs[3].exp_cyc = {4'd12, 4'd12, 4'd12, 4'd12};
    vecs[4].img = 8'h8D; vecs[4].exp_cyc = {4'd8,  4'd0,  4'd12, 4'd4};

    repeat (2) @(posedge clk);
    #1;
    check("reset_row", {30'd0, row}, 32'd0);
    check("reset_col", {30'd0, col}, 32'd3);
    check("reset_fs", {31'd0, frame_start}, 32'd0);
    check("reset_pending", {31'd0, pending}, 32'd0);
    rst_n = 1'b1;

    // PWM table: load mid-frame, shown from the next frame_start
    for (int i = 0; i < 5; i++) begin
      align(5);
      cycle(1'b1, 1'b1, vecs[i].img);
      count_frame(vecs[i].exp_cyc, "pwm_table");
    end

    // load B on the exact swap clock while A is pending
    align(5);
    cycle(1'b1, 1'b1, vecs[1].img);
    align(31);
    cycle(1'b1, 1'b1, vecs[0].img);
    check("swap_load_pending", {31'd0, obs_pend}, 32'd1);
    count_frame(vecs[1].exp_cyc, "swap_frame_a");
    count_frame(vecs[0].exp_cyc, "swap_frame_b");

    // enable low in the middle of row 1
    align(20);
    repeat (10) cycle(1'b0, 1'b0, img);
    cycle(1'b1, 1'b0, img);
    check("reenable_fs", {31'd0, obs_fs}, 32'd1);
    n = 0;
    while ((obs_row == 2'b00) && (n < 40)) begin
      cycle(1'b1, 1'b0, img);
      n++;
    end
    check("reenable_row0_first", {30'd0, obs_row}, 32'd1);

    // asynchronous reset between clock edges with a frame pending
    align(20);
    cycle(1'b1, 1'b1, vecs[3].img);
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_row", {30'd0, row}, 32'd0);
    check("async_rst_col", {30'd0, col}, 32'd3);
    check("async_rst_pending", {31'd0, pending}, 32'd0);
    check("async_rst_fs", {31'd0, frame_start}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_row", {30'd0, row}, 32'd0);
    check("rst_hold_col", {30'd0, col}, 32'd3);
    rst_n     = 1'b1;
    m_t       = 0;
    m_act     = 8'h00;
    m_pend    = 8'h00;
    m_pending = 1'b0;
    count_frame(16'h0000, "post_reset_blank");

    // ten frames: frame_start spacing
    last_fs = -1;
    n_fs    = 0;
    for (int k = 0; k < FRM * 10; k++) begin
      cycle(1'b1, 1'b0, img);
      if (obs_fs) begin
        if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FRM));
        last_fs = cyc;
        n_fs++;
      end
    end
    check("fs_count", 32'(n_fs), 32'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
